// File: rtl/datapath_mux_pkg.sv
// -----------------------------------------------------------------------------
// datapath_mux_pkg
//
// Purpose: shared select encodings and link defaults for the write-back /
//          operand steering block (datapath_mux) and its 4-to-1 mux.
//
// Contents:
//   reg_dst_e   - destination register select (rt / rd / link / reserved)
//   wb_sel_e    - write-back data select (ALU / memory / link / reserved)
//   alu_src_e   - ALU B operand select (register / immediate)
//   DEF_LINK_REG, DEF_LINK_OFS - defaults for the link destination and offset
//   is_rsvd_*   - helpers flagging the reserved encodings
// -----------------------------------------------------------------------------
package datapath_mux_pkg;

    localparam int DEF_LINK_REG = 31;
    localparam int DEF_LINK_OFS = 4;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_LINK = 2'b10,
        REGDST_RSVD = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic {
        ALUSRC_REG = 1'b0,
        ALUSRC_IMM = 1'b1
    } alu_src_e;

    // Equality (not case) so an X select propagates an X flag instead of
    // silently falling into a default branch.
    function automatic logic is_rsvd_reg_dst(input logic [1:0] sel);
        return (sel == REGDST_RSVD);
    endfunction

    function automatic logic is_rsvd_wb_sel(input logic [1:0] sel);
        return (sel == WB_RSVD);
    endfunction

endpackage

// File: rtl/datapath_mux_sel_mux4.sv
// -----------------------------------------------------------------------------
// sel_mux4
//
// Purpose: width-parameterised 4-to-1 selector used for the destination
//          register address and the write-back data.
//
// Parameters:
//   W      - data width
// Ports:
//   sel    in  2   select (00 -> in0, 01 -> in1, 10 -> in2, 11 -> in3)
//   in0..3 in  W   candidate sources
//   out    out W   selected source
// -----------------------------------------------------------------------------
module sel_mux4
    import datapath_mux_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out
);

    // Nested ternaries rather than a case statement: an unknown select bit
    // yields unknown output bits instead of being resolved to one branch.
    logic [W-1:0] lo_pair;
    logic [W-1:0] hi_pair;

    assign lo_pair = sel[0] ? in1 : in0;
    assign hi_pair = sel[0] ? in3 : in2;
    assign out     = sel[1] ? hi_pair : lo_pair;

endmodule

// File: rtl/datapath_mux.sv
// -----------------------------------------------------------------------------
// datapath_mux
//
// Purpose: steers the register-file write address, the write-back data and
//          the ALU B operand for a MIPS-style datapath, and flags use of the
//          reserved select encodings.
//
// Configuration macro:
//   DATAPATH_MUX_REG_OUT_EN - when defined, all four outputs are registered
//                             on rising clk (1-cycle latency) and cleared by
//                             the synchronous active-low reset. When
//                             undefined, outputs are purely combinational and
//                             clk/reset are ignored; the port list is the same.
//
// Parameters:
//   DATA_W   - datapath word width
//   REG_AW   - register-file address width
//   LINK_REG - destination register for link writes
//   LINK_OFS - offset added to pc for the link value
//
// Ports:
//   clk             in  1       rising-edge clock
//   reset           in  1       synchronous active-low reset
//   reg_dst         in  2       destination select (rt/rd/link/reserved)
//   rt              in  REG_AW  instruction field [20:16]
//   rd              in  REG_AW  instruction field [15:11]
//   data_to_reg_sel in  2       write-back select (alu/mem/link/reserved)
//   alu_out         in  DATA_W  ALU result
//   dm_out          in  DATA_W  data-memory read data
//   pc              in  DATA_W  current PC
//   alu_src         in  1       ALU B select (register/immediate)
//   gpr_b           in  DATA_W  register-file port B data
//   ext_imm         in  DATA_W  extended immediate
//   reg_rd          out REG_AW  selected write address
//   wb_data         out DATA_W  selected write-back data
//   alu_b           out DATA_W  selected ALU B operand
//   sel_err         out 1       a reserved select encoding is in use
// -----------------------------------------------------------------------------
module datapath_mux
    import datapath_mux_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = DEF_LINK_REG,
    parameter int LINK_OFS = DEF_LINK_OFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        reg_dst,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [1:0]        data_to_reg_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] dm_out,
    input  logic [DATA_W-1:0] pc,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] gpr_b,
    input  logic [DATA_W-1:0] ext_imm,
    output logic [REG_AW-1:0] reg_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_b,
    output logic              sel_err
);

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
    localparam logic [DATA_W-1:0] LINK_INC  = DATA_W'(LINK_OFS);

    logic [DATA_W-1:0] link_val;
    logic [REG_AW-1:0] reg_rd_mux;
    logic [DATA_W-1:0] wb_data_mux;

    logic [REG_AW-1:0] reg_rd_d;
    logic [DATA_W-1:0] wb_data_d;
    logic [DATA_W-1:0] alu_b_d;
    logic              sel_err_d;

    // Natural DATA_W-bit addition: the carry out is dropped so the link
    // value wraps modulo 2^DATA_W.
    assign link_val = pc + LINK_INC;

    sel_mux4 #(
        .W (REG_AW)
    ) u_reg_rd_mux (
        .sel (reg_dst),
        .in0 (rt),
        .in1 (rd),
        .in2 (LINK_ADDR),
        .in3 ('0),
        .out (reg_rd_mux)
    );

    sel_mux4 #(
        .W (DATA_W)
    ) u_wb_data_mux (
        .sel (data_to_reg_sel),
        .in0 (alu_out),
        .in1 (dm_out),
        .in2 (link_val),
        .in3 ('0),
        .out (wb_data_mux)
    );

    always_comb begin
        reg_rd_d  = reg_rd_mux;
        wb_data_d = wb_data_mux;
        alu_b_d   = (alu_src == ALUSRC_IMM) ? ext_imm : gpr_b;
        sel_err_d = is_rsvd_reg_dst(reg_dst) | is_rsvd_wb_sel(data_to_reg_sel);
    end

`ifdef DATAPATH_MUX_REG_OUT_EN

    logic [REG_AW-1:0] reg_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              sel_err_q;

    // Output register stage; reset wins over any selection presented on
    // the same edge, so a pending selection is discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_rd_q  <= '0;
            wb_data_q <= '0;
            alu_b_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            reg_rd_q  <= reg_rd_d;
            wb_data_q <= wb_data_d;
            alu_b_q   <= alu_b_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign reg_rd  = reg_rd_q;
    assign wb_data = wb_data_q;
    assign alu_b   = alu_b_q;
    assign sel_err = sel_err_q;

`else

    // clk and reset are kept on the port list for drop-in compatibility with
    // the registered build but have no function here.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign reg_rd  = reg_rd_d;
    assign wb_data = wb_data_d;
    assign alu_b   = alu_b_d;
    assign sel_err = sel_err_d;

`endif

endmodule

// File: tb/tb_datapath_mux.sv
module tb_datapath_mux;

    logic        clk;
    logic        reset;
    logic [1:0]  reg_dst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  data_to_reg_sel;
    logic [31:0] alu_out;
    logic [31:0] dm_out;
    logic [31:0] pc;
    logic        alu_src;
    logic [31:0] gpr_b;
    logic [31:0] ext_imm;
    logic [4:0]  reg_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_b;
    logic        sel_err;

    int checks;
    int errors;

    datapath_mux #(
        .DATA_W   (32),
        .REG_AW   (5),
        .LINK_REG (31),
        .LINK_OFS (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_dst         (reg_dst),
        .rt              (rt),
        .rd              (rd),
        .data_to_reg_sel (data_to_reg_sel),
        .alu_out         (alu_out),
        .dm_out          (dm_out),
        .pc              (pc),
        .alu_src         (alu_src),
        .gpr_b           (gpr_b),
        .ext_imm         (ext_imm),
        .reg_rd          (reg_rd),
        .wb_data         (wb_data),
        .alu_b           (alu_b),
        .sel_err         (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge, which is valid for both builds.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset           = 1'b0;
        rt              = 5'd8;
        rd              = 5'd9;
        reg_dst         = 2'b01;
        data_to_reg_sel = 2'b01;
        dm_out          = 32'h0000ABCD;
        alu_src         = 1'b1;
        ext_imm         = 32'hFFFF8000;
        tick();
`ifdef DATAPATH_MUX_REG_OUT_EN
        checks++; if (reg_rd !== 5'd0) begin errors++; $display("FAIL reset_reg_rd: got %0h want 0", reg_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
        checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_b: got %0h want 0", alu_b); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %0b want 0", sel_err); end
`else
        // Combinational build: reset low has no effect.
        checks++; if (reg_rd !== 5'd9) begin errors++; $display("FAIL reset_ignored_reg_rd: got %0h want 9", reg_rd); end
        checks++; if (wb_data !== 32'h0000ABCD) begin errors++; $display("FAIL reset_ignored_wb_data: got %0h want abcd", wb_data); end
        checks++; if (alu_b !== 32'hFFFF8000) begin errors++; $display("FAIL reset_ignored_alu_b: got %0h want ffff8000", alu_b); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_ignored_sel_err: got %0b want 0", sel_err); end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reg_dst();
        logic [4:0] exp_rd  [0:3];
        logic       exp_err [0:3];
        exp_rd  = '{5'd8, 5'd9, 5'd31, 5'd0};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        rt              = 5'd8;
        rd              = 5'd9;
        data_to_reg_sel = 2'b00;
        alu_out         = 32'h00000012;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reg_dst = 2'(i);
            tick();
            checks++; if (reg_rd !== exp_rd[i]) begin errors++; $display("FAIL reg_dst_%0d reg_rd: got %0d want %0d", i, reg_rd, exp_rd[i]); end
            checks++; if (sel_err !== exp_err[i]) begin errors++; $display("FAIL reg_dst_%0d sel_err: got %0b want %0b", i, sel_err, exp_err[i]); end
            checks++; if (wb_data !== 32'h12) begin errors++; $display("FAIL reg_dst_%0d wb_data_indep: got %0h want 12", i, wb_data); end
        end
    endtask

    task automatic test_wb_sel();
        logic [31:0] exp_wb  [0:3];
        logic        exp_err [0:3];
        exp_wb  = '{32'h12, 32'hABCD, 32'h3004, 32'h0};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        reg_dst = 2'b00;
        rt      = 5'd8;
        alu_out = 32'h00000012;
        dm_out  = 32'h0000ABCD;
        pc      = 32'h00003000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_to_reg_sel = 2'(i);
            tick();
            checks++; if (wb_data !== exp_wb[i]) begin errors++; $display("FAIL wb_sel_%0d wb_data: got %0h want %0h", i, wb_data, exp_wb[i]); end
            checks++; if (sel_err !== exp_err[i]) begin errors++; $display("FAIL wb_sel_%0d sel_err: got %0b want %0b", i, sel_err, exp_err[i]); end
            checks++; if (reg_rd !== 5'd8) begin errors++; $display("FAIL wb_sel_%0d reg_rd_indep: got %0d want 8", i, reg_rd); end
        end
    endtask

    task automatic test_link_wrap();
        @(negedge clk);
        reg_dst         = 2'b10;
        data_to_reg_sel = 2'b10;
        pc              = 32'hFFFFFFFC;
        tick();
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL link_wrap wb_data: got %0h want 0", wb_data); end
        checks++; if (reg_rd !== 5'd31) begin errors++; $display("FAIL link_wrap reg_rd: got %0d want 31", reg_rd); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL link_wrap sel_err: got %0b want 0", sel_err); end
        @(negedge clk);
        pc = 32'hFFFFFFF8;
        tick();
        checks++; if (wb_data !== 32'hFFFFFFFC) begin errors++; $display("FAIL link_near_wrap wb_data: got %0h want fffffffc", wb_data); end
    endtask

    task automatic test_alu_src();
        @(negedge clk);
        reg_dst         = 2'b01;
        rd              = 5'd9;
        data_to_reg_sel = 2'b01;
        dm_out          = 32'h0000ABCD;
        gpr_b           = 32'h00000005;
        ext_imm         = 32'hFFFF8000;
        alu_src         = 1'b0;
        tick();
        checks++; if (alu_b !== 32'h5) begin errors++; $display("FAIL alu_src_reg alu_b: got %0h want 5", alu_b); end
        @(negedge clk);
        alu_src = 1'b1;
        tick();
        checks++; if (alu_b !== 32'hFFFF8000) begin errors++; $display("FAIL alu_src_imm alu_b: got %0h want ffff8000", alu_b); end
        checks++; if (reg_rd !== 5'd9) begin errors++; $display("FAIL alu_src_imm reg_rd_indep: got %0d want 9", reg_rd); end
        checks++; if (wb_data !== 32'hABCD) begin errors++; $display("FAIL alu_src_imm wb_data_indep: got %0h want abcd", wb_data); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        alu_src = 1'b0;
        gpr_b   = 32'h00000005;
        ext_imm = 32'hFFFF8000;
        tick();
        @(negedge clk);
        alu_src = 1'b1;
        #1;
`ifdef DATAPATH_MUX_REG_OUT_EN
        checks++; if (alu_b !== 32'h5) begin errors++; $display("FAIL latency_before_edge alu_b: got %0h want 5", alu_b); end
`else
        checks++; if (alu_b !== 32'hFFFF8000) begin errors++; $display("FAIL zero_latency alu_b: got %0h want ffff8000", alu_b); end
`endif
        tick();
        checks++; if (alu_b !== 32'hFFFF8000) begin errors++; $display("FAIL latency_after_edge alu_b: got %0h want ffff8000", alu_b); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        reg_dst         = 2'b00;
        rt              = 5'd8;
        data_to_reg_sel = 2'b00;
        alu_out         = 32'h00000012;
        alu_src         = 1'b0;
        gpr_b           = 32'h00000005;
        tick();
        // New selection and reset presented on the same edge.
        @(negedge clk);
        reset           = 1'b0;
        reg_dst         = 2'b11;
        data_to_reg_sel = 2'b10;
        pc              = 32'h00003000;
        alu_src         = 1'b1;
        ext_imm         = 32'hFFFF8000;
        tick();
`ifdef DATAPATH_MUX_REG_OUT_EN
        checks++; if (reg_rd !== 5'd0) begin errors++; $display("FAIL mid_reset reg_rd: got %0d want 0", reg_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL mid_reset wb_data: got %0h want 0", wb_data); end
        checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL mid_reset alu_b: got %0h want 0", alu_b); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL mid_reset sel_err: got %0b want 0", sel_err); end
`else
        checks++; if (wb_data !== 32'h3004) begin errors++; $display("FAIL comb_reset_track wb_data: got %0h want 3004", wb_data); end
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL comb_reset_track sel_err: got %0b want 1", sel_err); end
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (reg_rd !== 5'd0) begin errors++; $display("FAIL resume reg_rd: got %0d want 0", reg_rd); end
        checks++; if (wb_data !== 32'h3004) begin errors++; $display("FAIL resume wb_data: got %0h want 3004", wb_data); end
        checks++; if (alu_b !== 32'hFFFF8000) begin errors++; $display("FAIL resume alu_b: got %0h want ffff8000", alu_b); end
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL resume sel_err: got %0b want 1", sel_err); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        reg_dst         = 2'b00;
        rt              = '0;
        rd              = '0;
        data_to_reg_sel = 2'b00;
        alu_out         = '0;
        dm_out          = '0;
        pc              = '0;
        alu_src         = 1'b0;
        gpr_b           = '0;
        ext_imm         = '0;

        test_reset();
        test_reg_dst();
        test_wb_sel();
        test_link_wrap();
        test_alu_src();
        test_latency();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_mux.md
DATAPATH_MUX -- requirements
Module: datapath_mux

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Parameter LINK_REG, default 31, destination register for link writes (jal).
REQ-004 Parameter LINK_OFS, default 4, offset added to the PC for the link value.
REQ-005 Clocking is fixed: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-low reset.
REQ-008 reg_dst  input  2  destination-register select.
REQ-009 rt  input  REG_AW  instruction field [20:16].
REQ-010 rd  input  REG_AW  instruction field [15:11].
REQ-011 data_to_reg_sel  input  2  write-back data select.
REQ-012 alu_out  input  DATA_W  ALU result.
REQ-013 dm_out  input  DATA_W  data-memory read data.
REQ-014 pc  input  DATA_W  current PC.
REQ-015 alu_src  input  1  ALU B-operand select.
REQ-016 gpr_b  input  DATA_W  register-file port B data.
REQ-017 ext_imm  input  DATA_W  extended immediate.
REQ-018 reg_rd  output  REG_AW  selected write address.
REQ-019 wb_data  output  DATA_W  selected write-back data.
REQ-020 alu_b  output  DATA_W  selected ALU B operand.
REQ-021 sel_err  output  1  reserved select encoding in use.

Function
REQ-022 reg_rd SHALL be selected by reg_dst: 00 gives rt; 01 gives rd; 10 gives LINK_REG; 11 gives 0.
REQ-023 wb_data SHALL be selected by data_to_reg_sel: 00 gives alu_out; 01 gives dm_out; 10 gives pc+LINK_OFS; 11 gives 0.
REQ-024 pc+LINK_OFS SHALL be computed modulo 2^DATA_W; 32'hFFFFFFFC wraps to 0.
REQ-025 alu_b SHALL be selected by alu_src: 0 gives gpr_b; 1 gives ext_imm.
REQ-026 sel_err SHALL be 1 when reg_dst==11 or data_to_reg_sel==11, and 0 otherwise.
REQ-027 The three selections SHALL be independent; changing any select SHALL affect only its own output (and sel_err).
REQ-028 Any X on a select input SHALL NOT be masked; outputs SHALL only be driven from the listed sources or constants.

Reset
REQ-029 Without REG_OUT_EN, clk and reset SHALL have no effect, and the outputs SHALL always track the inputs combinationally.
REQ-030 With REG_OUT_EN, when reset==0 at a rising clk edge, reg_rd, wb_data, alu_b and sel_err SHALL all be 0 after that edge.
REQ-031 Reset SHALL take priority over new data on the same edge.
REQ-032 Asserting reset mid-stream SHALL discard the pending selection.

Configuration
REQ-033 Macro DATAPATH_MUX_REG_OUT_EN defined: all four outputs SHALL be registered on rising clk, giving 1-cycle latency from any input change.
REQ-034 Macro DATAPATH_MUX_REG_OUT_EN undefined: zero-latency combinational outputs; the ports SHALL be unchanged.

Structure
REQ-035 Package datapath_mux_pkg SHALL hold the select encodings as typedef enums: REGDST_RT/RD/LINK/RSVD, WB_ALU/MEM/LINK/RSVD, ALUSRC_REG/IMM.
REQ-036 The package SHALL also hold the LINK_REG and LINK_OFS defaults.
REQ-037 One sub-module, sel_mux4 (width-parameterised, 4-to-1), SHALL be instantiated for reg_rd and wb_data; alu_b SHALL use a 2-to-1 select.

Verification
REQ-038 Register-destination select: rt=5'd8, rd=5'd9, reg_dst=00/01/10/11 -> reg_rd=8/9/31/0; sel_err=1 only for 11.
REQ-039 Write-back select: alu_out=32'h12, dm_out=32'hABCD, pc=32'h3000, data_to_reg_sel=00/01/10 -> wb_data=12/ABCD/3004.
REQ-040 Link wrap-around: pc=32'hFFFFFFFC, data_to_reg_sel=10 -> wb_data=0.
REQ-041 ALU operand select: gpr_b=32'h5, ext_imm=32'hFFFF8000, alu_src=0 then 1 -> alu_b=5 then FFFF8000.
REQ-042 Registered mode, latency: with DATAPATH_MUX_REG_OUT_EN defined, an input change shall appear at the outputs one edge later.
REQ-043 Registered mode, reset: with DATAPATH_MUX_REG_OUT_EN defined, reset=0 for one edge with active inputs -> all outputs 0; outputs resume the following edge after release.
